stg3_rd: RTL and testbench

- Read-side controller for the stage-3 polynomial banks: the consumer of the N_POLY parallel write ports that stage 3 drives.
- On a start pulse it walks a contiguous address range, issuing one read per cycle to all N_POLY banks at the same address.
- It absorbs the fixed bank read latency and presents each returned coefficient vector as a valid/ready stream with a last flag.
- Issue is credit-throttled so downstream backpressure never drops a returning word.

---
 rtl/stg3_pkg.sv | 14 +
 rtl/stg3_rd_fifo.sv | 55 +++++
 rtl/stg3_rd.sv | 122 ++++++++++++
 tb/tb_stg3_rd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stg3_pkg.sv
// Shared types and default sizing for the stage-3 polynomial bank read side.
`timescale 1ns/1ps
package stg3_pkg;
  localparam int STG3_DATA_WIDTH = 64;
  localparam int STG3_ADDR_WIDTH = 12;
  localparam int STG3_N_POLY     = 6;
  localparam int STG3_RD_LAT     = 2;
  localparam int STG3_FIFO_DEPTH = 4;
  localparam int CNT_W           = $clog2(STG3_FIFO_DEPTH) + 1;

  typedef logic [STG3_ADDR_WIDTH-1:0] addr_t;
  typedef logic [STG3_N_POLY*STG3_DATA_WIDTH-1:0] coef_vec_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;
endpackage

// File: rtl/stg3_rd_fifo.sv
// First-word-fall-through return buffer; the head entry is visible whenever not empty.
`timescale 1ns/1ps
module stg3_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Credit accounting upstream must make a push into a full buffer impossible.
  always @(posedge clk) begin
    if (rst_n && push && !pop_ok) assert (count_reg < CNT_W'(DEPTH));
  end

  assign rdata = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;
endmodule

// File: rtl/stg3_rd.sv
// Stage-3 bank read controller: walks an address range across all banks and
// streams the returned coefficient vectors out with credit-based flow control.
`timescale 1ns/1ps
module stg3_rd
  import stg3_pkg::*;
#(
  parameter int DATA_WIDTH = STG3_DATA_WIDTH,
  parameter int ADDR_WIDTH = STG3_ADDR_WIDTH,
  parameter int N_POLY     = STG3_N_POLY,
  parameter int RD_LAT     = STG3_RD_LAT,
  parameter int FIFO_DEPTH = STG3_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [ADDR_WIDTH-1:0]        i_base,
  input  logic [ADDR_WIDTH:0]          i_len,
  output logic [N_POLY-1:0]            o_re,
  output logic [N_POLY*ADDR_WIDTH-1:0] o_addr,
  input  logic [N_POLY*DATA_WIDTH-1:0] i_rdata,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [N_POLY*DATA_WIDTH-1:0] o_data,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int VW = N_POLY * DATA_WIDTH;

  rd_state_e             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   remain_reg;
  logic [CW-1:0]         used_reg;
  logic                  done_reg;
  logic [RD_LAT-1:0]     pipe_v_reg, pipe_l_reg;

  logic          start_ok, issue, pop, drain_done;
  logic          fifo_empty, head_last;
  logic [VW-1:0] head_data;
  logic [CW-1:0] fifo_count;

  assign start_ok = (state_reg == IDLE) && i_start;
  // used_reg counts reads in flight plus buffered beats; credit is what remains.
  assign issue    = (state_reg == ISSUE) && (used_reg < CW'(FIFO_DEPTH));
  assign pop      = !fifo_empty && i_ready;
  assign drain_done = (state_reg == DRAIN) && pop && head_last &&
                      (fifo_count == CW'(1)) && (pipe_v_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start && (i_len != '0)) state_next = ISSUE;
      ISSUE:   if (issue && (remain_reg == (ADDR_WIDTH+1)'(1))) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_re   = {N_POLY{issue}};
    o_busy = (state_reg != IDLE);
    o_done = done_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      remain_reg <= '0;
      used_reg   <= '0;
      done_reg   <= 1'b0;
      pipe_v_reg <= '0;
      pipe_l_reg <= '0;
    end else begin
      if (start_ok && (i_len != '0)) begin
        addr_reg   <= i_base;
        remain_reg <= i_len;
      end else if (issue) begin
        addr_reg   <= addr_reg + ADDR_WIDTH'(1);
        remain_reg <= remain_reg - (ADDR_WIDTH+1)'(1);
      end
      case ({issue, pop})
        2'b10:   used_reg <= used_reg + CW'(1);
        2'b01:   used_reg <= used_reg - CW'(1);
        default: used_reg <= used_reg;
      endcase
      done_reg   <= (start_ok && (i_len == '0)) || drain_done;
      // The last tag rides alongside the read so it lands with the right beat.
      pipe_v_reg <= (pipe_v_reg << 1) | RD_LAT'(issue);
      pipe_l_reg <= (pipe_l_reg << 1) |
                    RD_LAT'(issue && (remain_reg == (ADDR_WIDTH+1)'(1)));
    end
  end

  for (genvar gi = 0; gi < N_POLY; gi++) begin : g_addr_lane
    assign o_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = addr_reg;
  end

  stg3_rd_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pipe_v_reg[RD_LAT-1]),
    .wdata ({pipe_l_reg[RD_LAT-1], i_rdata}),
    .pop   (pop),
    .rdata ({head_last, head_data}),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = fifo_empty ? '0 : head_data;
  assign o_last  = !fifo_empty && head_last;
endmodule

// File: tb/tb_stg3_rd.sv
// Scoreboard bench for stg3_rd: stimulus queues expected reads/beats, a monitor checks them.
`timescale 1ns/1ps
module tb_stg3_rd;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int NP = 6;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [AW-1:0]     i_base = '0;
  logic [AW:0]       i_len = '0;
  logic [NP-1:0]     o_re;
  logic [NP*AW-1:0]  o_addr;
  logic [NP*DW-1:0]  i_rdata;
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic [NP*DW-1:0]  o_data;
  logic              o_last;
  logic              o_busy;
  logic              o_done;

  stg3_rd dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_base  (i_base),
    .i_len   (i_len),
    .o_re    (o_re),
    .o_addr  (o_addr),
    .i_rdata (i_rdata),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NP*DW:0] exp_q[$];
  logic [AW-1:0]  addr_q[$];
  int   issued = 0;
  int   popped = 0;
  logic done_pend = 1'b0;
  logic prev_stall = 1'b0;
  logic [NP*DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  function automatic logic [DW-1:0] bank_word(input logic [AW-1:0] a, input int k);
    return {16'(k + 1), 4'h0, a, 32'hC0DE_0000 | {20'h0, a}};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bank model: data follows the address by two cycles.
  logic [AW-1:0] a_d0 = '0, a_d1 = '0;
  always @(posedge clk) begin
    a_d0 <= o_addr[AW-1:0];
    a_d1 <= a_d0;
  end
  always_comb begin
    i_rdata = '0;
    for (int k = 0; k < NP; k++) i_rdata[k*DW +: DW] = bank_word(a_d1, k);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [AW-1:0]  ea;
    logic [NP*DW:0] eb;
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      issued = 0;
      popped = 0;
      done_pend = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done_pend) begin
        chk("done_after_last", {o_done, o_busy}, 2'b10);
        done_pend = 1'b0;
      end
      if (o_re[0]) begin
        chk("re_lanes", o_re, {NP{1'b1}});
        chk("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          chk("addr", o_addr, {NP{ea}});
        end
        chk("credit", (issued - popped) < FD, 1);
        issued++;
      end
      if (prev_stall) chk("stall_hold", {o_valid, o_last, o_data}, {1'b1, prev_last, prev_data});
      if (o_valid && i_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          chk("beat", {o_last, o_data}, eb);
          $display("beat %0d last=%0b data[31:0]=%h", popped, o_last, o_data[31:0]);
        end
        popped++;
        if (o_last) done_pend = 1'b1;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  task automatic push_expect(input logic [AW-1:0] base, input int len);
    logic [AW-1:0]  a;
    logic [NP*DW:0] e;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      addr_q.push_back(a);
      e = '0;
      for (int k = 0; k < NP; k++) e[k*DW +: DW] = bank_word(a, k);
      e[NP*DW] = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input int len);
    push_expect(base, len);
    @(posedge clk); #1;
    i_base = base; i_len = (AW+1)'(len); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    $display("start base=%h len=%0d", base, len);
  endtask

  task automatic wait_idle(input string nm);
    bit to = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (!o_busy && exp_q.size() == 0) begin to = 1'b0; break; end
    end
    chk({nm, "_timeout"}, to, 0);
    chk({nm, "_drained"}, addr_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int base_iss;
    bit to;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {o_re, o_valid, o_busy, o_done, o_last}, 0);
    rst_n = 1'b1;

    // T1: basic transfer, latency
    push_expect(12'h010, 8);
    @(posedge clk); #1;
    i_base = 12'h010; i_len = 13'd8; i_start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
      end
    end while (!o_valid && n < 20);
    chk("first_valid_latency", n, 4);
    wait_idle("t1");

    // T2: address wrap
    start_xfer(12'hFFE, 4);
    wait_idle("t2_wrap");

    // T3: backpressure caps outstanding reads at buffer depth
    base_iss = issued;
    i_ready = 1'b0;
    start_xfer(12'h040, 16);
    repeat (9) @(posedge clk);
    #1;
    chk("reads_under_stall", issued - base_iss, 4);
    chk("no_re_when_full", o_re, 0);
    i_ready = 1'b1;
    wait_idle("t3");

    // T4: alternating ready
    start_xfer(12'h080, 32);
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      i_ready = ~i_ready;
      if (!o_busy && exp_q.size() == 0) begin to = 1'b0; break; end
    end
    i_ready = 1'b1;
    chk("t4_timeout", to, 0);
    chk("t4_drained", addr_q.size() + exp_q.size(), 0);

    // T5: zero-length start, then an ignored start mid-transfer
    @(posedge clk); #1;
    i_base = 12'h555; i_len = '0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("len0_done", {o_done, o_busy, |o_re}, 3'b100);
    @(posedge clk); #1;
    chk("len0_after", {o_done, o_busy}, 2'b00);
    start_xfer(12'h300, 8);
    repeat (2) @(posedge clk);
    #1;
    i_base = 12'h400; i_len = 13'd5; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_idle("t5_ignored_start");

    // T6: reset with reads in flight
    start_xfer(12'h200, 8);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_abort_outputs", {o_re, o_addr, o_valid, o_data, o_last, o_busy, o_done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_xfer(12'h100, 2);
    wait_idle("t6_after_reset");
    repeat (10) @(posedge clk);
    #1;
    chk("beats_after_reset", popped, 2);
    chk("idle_no_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
